mc_stage_ctrl: RTL and testbench
================================

Name: mc_stage_ctrl

Overview:
- Parametrised stage sequencer for the multi-cycle LA32R core.
- Owns the PC and the IF/ID/EXE/MEM/WB state machine, and paces each stage with req/ack handshakes to variable-latency instruction and data SRAM.
- Produces stage enables, register-file write strobe, retire pulse and debug PC.
- The datapath (decoder, regfile, ALU) sits beside it and supplies the instruction-class flags and the branch result.

Parameters:
- PC_W, 32: PC and address width.
- RESET_PC, 32'h1c00_0000: PC loaded at reset.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- inst_req  out  1  fetch request, held high in IF until acked.
- inst_addr  out  PC_W  fetch address (= pc).
- inst_ack  in  1  fetch data valid this cycle.
- ir_we  out  1  latch inst_sram_rdata into the instruction register.
- cls_load  in  1  decoded instruction is ld.w; valid ID..WB.
- cls_store  in  1  decoded instruction is st.w.
- cls_br_only  in  1  b/beq/bne: no register write, no memory access.
- cls_gr_we  in  1  instruction writes the GPR file.
- br_taken  in  1  branch or jump taken; sampled in EXE.
- br_target  in  PC_W  taken target; sampled in EXE.
- data_req  out  1  data SRAM request, held in MEM until acked.
- data_we  out  1  store qualifier (= data_req & cls_store).
- data_ack  in  1  data access complete; load data valid this cycle.
- mdr_we  out  1  latch load data.
- exe_en  out  1  high in EXE; ALU result register enable.
- rf_we  out  1  one-cycle GPR write strobe.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.
- pc  out  PC_W  PC of the instruction in flight.
- state  out  3  IF=0, ID=1, EXE=2, MEM=3, WB=4.
- cycle_cnt / retire_cnt / stall_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (async assert, sync release by clock edge):
  - state=IF, pc=RESET_PC, internal take/target regs cleared.
  - All strobes and counters are 0.
  - Reset asserted mid-transaction drops inst_req/data_req in the same cycle, and any later ack is ignored.
- inst_req = (state==IF) and resetn sampled high. inst_addr = pc, stable while inst_req is high.
- IF:
  - Stays in IF while !inst_ack.
  - On inst_ack: ir_we=1 for that cycle, next=ID. Zero-wait ack in the first IF cycle is legal.
- ID: exactly 1 cycle; next=EXE.
- EXE: exe_en=1. Latch take_q=br_taken, tgt_q=br_target. Next state:
  - cls_br_only -> IF, and the instruction retires this cycle.
  - cls_load|cls_store -> MEM.
  - otherwise -> WB (covers jirl, bl, ALU ops).
- MEM:
  - data_req=1 until data_ack.
  - On ack with cls_load: mdr_we=1, next=WB.
  - On ack with cls_store: retire, next=IF.
- WB: rf_we=cls_gr_we, retire=1, next=IF. Always 1 cycle.
- PC update: only on the retire cycle.
  - pc <= take_q ? tgt_q : pc+4 (mod 2^PC_W, wraps silently).
  - In the EXE br_only retire case, the just-sampled br_taken/br_target are used directly.
  - pc observed while retire=1 is the retiring instruction's PC (debug_wb_pc).
- Acks outside their owning state are ignored: inst_ack outside IF, data_ack outside MEM.
- Instruction latencies with zero-wait SRAM:
  - ALU op: 4 cycles.
  - br_only: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Each SRAM wait cycle adds 1.
- Illegal state encodings (5..7) -> IF next cycle, with no retire.

Optional Feature:
- MC_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle out of reset.
  - retire_cnt increments on each retire.
  - stall_cnt increments each cycle with (inst_req&!inst_ack)|(data_req&!data_ack).
  - All counters wrap at 2^CNT_W.
- Not defined: the three counter ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset release, inst_ack tied 1, ALU stream -> first inst_addr=0x1c000000, then retire every 4 cycles, pc 0x1c000000,0x1c000004,0x1c000008; rf_we coincides with retire.
- inst_ack delayed 3 cycles on the 2nd fetch -> inst_req held with inst_addr=0x1c000004 stable for 4 cycles, ir_we single pulse, stall_cnt=3 (with MC_PERF_CNT_EN).
- beq taken, br_target=0x1c000100 -> state sequence IF,ID,EXE,IF; retire in EXE with rf_we=0; next inst_addr=0x1c000100. Not taken -> next inst_addr=pc+4.
- ld.w with data_ack after 2 waits -> MEM lasts 3 cycles; mdr_we on the ack cycle; WB rf_we=1 next cycle; total 7 cycles.
- st.w zero-wait -> data_we=1 for 1 cycle, retire in MEM, rf_we never asserted.
- resetn pulled low mid-MEM with data_req=1 -> data_req=0 immediately, pc=0x1c000000 and state=IF after release; a stray data_ack is ignored; counters reset to 0.

Source files
------------

// File: rtl/mc_stage_ctrl.sv
// Multi-cycle LA32R stage sequencer: PC, IF/ID/EXE/MEM/WB FSM and SRAM req/ack pacing.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module mc_stage_ctrl #(
    parameter int               PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(32'h1c00_0000),
    parameter int               CNT_W    = 32
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             inst_req,
    output logic [PC_W-1:0]  inst_addr,
    input  logic             inst_ack,
    output logic             ir_we,
    input  logic             cls_load,
    input  logic             cls_store,
    input  logic             cls_br_only,
    input  logic             cls_gr_we,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    output logic             data_req,
    output logic             data_we,
    input  logic             data_ack,
    output logic             mdr_we,
    output logic             exe_en,
    output logic             rf_we,
    output logic             retire,
    output logic [PC_W-1:0]  pc,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            take_q;
    logic [PC_W-1:0] tgt_q;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IF;
            pc_q    <= RESET_PC;
            take_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == S_EXE) begin
                take_q <= br_taken;
                tgt_q  <= br_target;
            end
        end
    end

    // Requests are gated by resetn so they drop the moment reset asserts.
    always_comb begin
        state_d     = S_IF;
        inst_req    = resetn && (state_q == S_IF);
        data_req    = resetn && (state_q == S_MEM);
        ir_we       = 1'b0;
        mdr_we      = 1'b0;
        exe_en      = 1'b0;
        rf_we       = 1'b0;
        retire      = 1'b0;
        redirect    = take_q;
        redirect_pc = tgt_q;
        case (state_q)
            S_IF: begin
                ir_we   = inst_req && inst_ack;
                state_d = (inst_req && inst_ack) ? S_ID : S_IF;
            end
            S_ID: state_d = S_EXE;
            S_EXE: begin
                exe_en = 1'b1;
                if (cls_br_only) begin
                    // Branch retires here, before take_q/tgt_q are written.
                    retire      = 1'b1;
                    redirect    = br_taken;
                    redirect_pc = br_target;
                    state_d     = S_IF;
                end else if (cls_load || cls_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (data_req && data_ack) begin
                    if (cls_load) begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                rf_we   = cls_gr_we;
                retire  = 1'b1;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
        pc_d = retire ? (redirect ? redirect_pc : pc_q + PC_W'(4)) : pc_q;
    end

    assign data_we   = data_req && cls_store;
    assign inst_addr = pc_q;
    assign pc        = pc_q;
    assign state     = state_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, retire_q, stall_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_q  <= '0;
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (retire)
                retire_q <= retire_q + CNT_W'(1);
            if ((inst_req && !inst_ack) || (data_req && !data_ack))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
    assign stall_cnt  = stall_q;
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_mc_stage_ctrl.sv
// Table-driven bench for mc_stage_ctrl: one record per cycle plus a hand-written reset-in-MEM sequence.
module tb_mc_stage_ctrl;

    localparam logic [31:0] R = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_ack, ir_we;
    logic [31:0] inst_addr;
    logic        cls_load, cls_store, cls_br_only, cls_gr_we;
    logic        br_taken;
    logic [31:0] br_target;
    logic        data_req, data_we, data_ack, mdr_we;
    logic        exe_en, rf_we, retire;
    logic [31:0] pc;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, retire_cnt, stall_cnt;

    mc_stage_ctrl dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .ir_we(ir_we),
        .cls_load(cls_load), .cls_store(cls_store), .cls_br_only(cls_br_only), .cls_gr_we(cls_gr_we),
        .br_taken(br_taken), .br_target(br_target),
        .data_req(data_req), .data_we(data_we), .data_ack(data_ack), .mdr_we(mdr_we),
        .exe_en(exe_en), .rf_we(rf_we), .retire(retire),
        .pc(pc), .state(state),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // in = {inst_ack, data_ack, load, store, br_only, gr_we, br_taken}
    // out = {inst_req, ir_we, data_req, data_we, mdr_we, exe_en, rf_we, retire}
    typedef struct {
        logic [6:0]  in;
        logic [31:0] tgt;
        logic [2:0]  st_e;
        logic [31:0] pc_e;
        logic [7:0]  out_e;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;
    int   exp_retires = 0;
    int   exp_stalls  = 0;

    function automatic vec_t mk(logic [6:0] in, logic [31:0] tgt, logic [2:0] s,
                                logic [31:0] p, logic [7:0] o);
        vec_t v;
        v.in = in; v.tgt = tgt; v.st_e = s; v.pc_e = p; v.out_e = o;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v, int idx);
        {inst_ack, data_ack, cls_load, cls_store, cls_br_only, cls_gr_we, br_taken} = v.in;
        br_target = v.tgt;
        #1;
        checkOutput($sformatf("vec%0d", idx),
                    {state, pc, inst_addr,
                     inst_req, ir_we, data_req, data_we, mdr_we, exe_en, rf_we, retire},
                    {v.st_e, v.pc_e, v.pc_e, v.out_e});
        @(negedge clk);
    endtask

    task automatic buildTable();
        logic [31:0] p;
        // Zero-wait ALU stream: 4 cycles per instruction, rf_we with retire.
        for (int k = 0; k < 3; k++) begin
            p = R + 32'(4 * k);
            vecs.push_back(mk(7'b1000010, 32'h0, 3'd0, p, 8'b1100_0000));
            vecs.push_back(mk(7'b1000010, 32'h0, 3'd1, p, 8'b0000_0000));
            vecs.push_back(mk(7'b1000010, 32'h0, 3'd2, p, 8'b0000_0100));
            vecs.push_back(mk(7'b1000010, 32'h0, 3'd4, p, 8'b0000_0011));
        end
        // Fetch acked after 3 wait cycles.
        p = R + 32'h0c;
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(7'b0000010, 32'h0, 3'd0, p, 8'b1000_0000));
        vecs.push_back(mk(7'b1000010, 32'h0, 3'd0, p, 8'b1100_0000));
        vecs.push_back(mk(7'b0000010, 32'h0, 3'd1, p, 8'b0000_0000));
        vecs.push_back(mk(7'b0000010, 32'h0, 3'd2, p, 8'b0000_0100));
        vecs.push_back(mk(7'b0000010, 32'h0, 3'd4, p, 8'b0000_0011));
        // beq taken to R+0x100, retires in EXE.
        p = R + 32'h10;
        vecs.push_back(mk(7'b1000000, 32'h0, 3'd0, p, 8'b1100_0000));
        vecs.push_back(mk(7'b0000100, 32'h0, 3'd1, p, 8'b0000_0000));
        vecs.push_back(mk(7'b0000101, R + 32'h100, 3'd2, p, 8'b0000_0101));
        // beq not taken: target is ignored.
        p = R + 32'h100;
        vecs.push_back(mk(7'b1000000, 32'h0, 3'd0, p, 8'b1100_0000));
        vecs.push_back(mk(7'b0000100, 32'h0, 3'd1, p, 8'b0000_0000));
        vecs.push_back(mk(7'b0000100, R + 32'h300, 3'd2, p, 8'b0000_0101));
        // ld.w with two data wait cycles: 7 cycles total.
        p = R + 32'h104;
        vecs.push_back(mk(7'b1000000, 32'h0, 3'd0, p, 8'b1100_0000));
        vecs.push_back(mk(7'b0010010, 32'h0, 3'd1, p, 8'b0000_0000));
        vecs.push_back(mk(7'b0010010, 32'h0, 3'd2, p, 8'b0000_0100));
        vecs.push_back(mk(7'b0010010, 32'h0, 3'd3, p, 8'b0010_0000));
        vecs.push_back(mk(7'b0010010, 32'h0, 3'd3, p, 8'b0010_0000));
        vecs.push_back(mk(7'b0110010, 32'h0, 3'd3, p, 8'b0010_1000));
        vecs.push_back(mk(7'b0010010, 32'h0, 3'd4, p, 8'b0000_0011));
        // st.w zero-wait, with a stray data_ack during IF.
        p = R + 32'h108;
        vecs.push_back(mk(7'b1100000, 32'h0, 3'd0, p, 8'b1100_0000));
        vecs.push_back(mk(7'b0001000, 32'h0, 3'd1, p, 8'b0000_0000));
        vecs.push_back(mk(7'b0001000, 32'h0, 3'd2, p, 8'b0000_0100));
        vecs.push_back(mk(7'b0101000, 32'h0, 3'd3, p, 8'b0011_0001));
        // jirl-like taken jump retiring in WB from the latched target.
        p = R + 32'h10c;
        vecs.push_back(mk(7'b1000000, 32'h0, 3'd0, p, 8'b1100_0000));
        vecs.push_back(mk(7'b0000010, 32'h0, 3'd1, p, 8'b0000_0000));
        vecs.push_back(mk(7'b0000011, R + 32'h200, 3'd2, p, 8'b0000_0100));
        vecs.push_back(mk(7'b0100010, 32'h0, 3'd4, p, 8'b0000_0011));
        // Branch to the top of the address space, then fall through and wrap to 0.
        p = R + 32'h200;
        vecs.push_back(mk(7'b1000000, 32'h0, 3'd0, p, 8'b1100_0000));
        vecs.push_back(mk(7'b0000100, 32'h0, 3'd1, p, 8'b0000_0000));
        vecs.push_back(mk(7'b0000101, 32'hffff_fffc, 3'd2, p, 8'b0000_0101));
        p = 32'hffff_fffc;
        vecs.push_back(mk(7'b1000000, 32'h0, 3'd0, p, 8'b1100_0000));
        vecs.push_back(mk(7'b0000100, 32'h0, 3'd1, p, 8'b0000_0000));
        vecs.push_back(mk(7'b0000100, 32'h0, 3'd2, p, 8'b0000_0101));
        vecs.push_back(mk(7'b0000000, 32'h0, 3'd0, 32'h0, 8'b1000_0000));
    endtask

    initial begin
        resetn = 1'b0;
        {inst_ack, data_ack, cls_load, cls_store, cls_br_only, cls_gr_we, br_taken} = '0;
        br_target = '0;
        buildTable();
        foreach (vecs[i]) begin
            if (vecs[i].out_e[0]) exp_retires++;
            if ((vecs[i].out_e[7] && !vecs[i].in[6]) || (vecs[i].out_e[5] && !vecs[i].in[5]))
                exp_stalls++;
        end

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_state",
                    {state, pc, inst_req, ir_we, data_req, data_we, mdr_we, exe_en, rf_we, retire,
                     cycle_cnt, retire_cnt, stall_cnt},
                    {3'd0, R, 8'b0, 96'b0});

        @(negedge clk);
        resetn = 1'b1;
        foreach (vecs[i]) applyStimulus(vecs[i], i);

`ifdef MC_PERF_CNT_EN
        checkOutput("counters", {cycle_cnt, retire_cnt, stall_cnt},
                    {32'(vecs.size()), 32'(exp_retires), 32'(exp_stalls)});
`else
        checkOutput("counters", {cycle_cnt, retire_cnt, stall_cnt}, 96'b0);
`endif

        // Walk a load into MEM, then pull reset while data_req is high.
        {inst_ack, data_ack, cls_load, cls_store, cls_br_only, cls_gr_we, br_taken} = 7'b1010010;
        for (int i = 0; i < 10 && state != 3'd3; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("reach_mem", {state, data_req}, {3'd3, 1'b1});
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("reset_mid_mem",
                    {state, pc, inst_req, data_req, cycle_cnt, retire_cnt, stall_cnt},
                    {3'd0, R, 1'b0, 1'b0, 96'b0});
        data_ack = 1'b1;
        @(negedge clk);
        resetn   = 1'b1;
        inst_ack = 1'b0;
        #1;
        checkOutput("release_stray_ack",
                    {state, pc, inst_req, ir_we, data_req, mdr_we, retire},
                    {3'd0, R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        #1;
`ifdef MC_PERF_CNT_EN
        checkOutput("after_release",
                    {state, pc, mdr_we, cycle_cnt, retire_cnt, stall_cnt},
                    {3'd0, R, 1'b0, 32'd1, 32'd0, 32'd1});
`else
        checkOutput("after_release",
                    {state, pc, mdr_we, cycle_cnt, retire_cnt, stall_cnt},
                    {3'd0, R, 1'b0, 96'b0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
